ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Two-master AHB-Lite bus arbiter: M1 is the CPU, M2 is the DMA, and master 0 is the internal default master.
- Generates HGRANT_M1/HGRANT_M2 and the registered HMASTER/HMASTLOCK.
- HMASTER is the select for the master-to-slave address/control/write-data mux, so this block decides which master owns the shared address and data phases.
- Supports fixed or round-robin priority, locked transfers and a burst-length fairness cap.

Parameters:
- RR_MODE, 0, 0 = fixed priority (M1 over M2); 1 = round-robin.
- MAX_BEATS, 16, number of owner beats before forced re-arbitration if the other master is requesting. 0 disables the cap. Range 0..255.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous active-low reset
- HREADY  input  1  bus ready, end of current data phase
- HTRANS  input  2  muxed bus HTRANS (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- HBUSREQ_M1  input  1  M1 bus request
- HLOCK_M1  input  1  M1 locked-transfer request
- HBUSREQ_M2  input  1  M2 bus request
- HLOCK_M2  input  1  M2 locked-transfer request
- HGRANT_M1  output  1  M1 granted
- HGRANT_M2  output  1  M2 granted
- HMASTER  output  2  address-phase owner: 0 = default, 1 = M1, 2 = M2
- HMASTLOCK  output  1  current address phase is locked

Behaviour:
- Reset (async, HRESETn=0):
  - Grant FSM = GNT_DEF; HGRANT_M1=0, HGRANT_M2=0, HMASTER=0, HMASTLOCK=0.
  - Beat counter = 0; RR last-served = M2 (so M1 wins the first tie).
  - Reset asserted mid-burst drops all grants immediately. No state survives.
- Grant FSM states: GNT_DEF, GNT_M1, GNT_M2. The FSM updates only on HCLK edges where HREADY=1; with HREADY=0 every register holds.
- HGRANT_Mx = (state == GNT_Mx). They are registered and always one-hot or zero.
- Owner retention: the current owner Mx keeps the grant while all of the following hold:
  - HBUSREQ_Mx=1, and
  - (MAX_BEATS=0, or beat count < MAX_BEATS, or the other master is not requesting).
- Lock override:
  - If the owner's HLOCK_Mx=1, or HMASTLOCK=1, the grant is held regardless of the beat cap or the other master's request.
  - This is the only case in which a master whose HBUSREQ is 0 still keeps the grant.
- Re-arbitration (when retention fails, or in GNT_DEF):
  - Only one master requesting: grant it.
  - Both requesting, RR_MODE=0: M1 wins.
  - Both requesting, RR_MODE=1: the master not in last-served wins.
  - Neither requesting: go to GNT_DEF.
- Last-served updates to the newly granted master on every transition into GNT_M1/GNT_M2.
- Beat counter:
  - Cleared on any grant state change.
  - Incremented on HREADY=1 when HMASTER equals the granted master and HTRANS is NONSEQ or SEQ.
  - Saturates at 255.
- HMASTER and HMASTLOCK, on HREADY=1:
  - HMASTER <= encoded grant state (DEF=0, M1=1, M2=2).
  - HMASTLOCK <= HLOCK of the granted master (0 for DEF).
  - With HREADY=0 both hold, so ownership hands over only at a transfer boundary.
- Latency:
  - Request asserted in cycle n with bus free and HREADY=1: HGRANT rises at n+1, HMASTER changes at n+2 if HREADY=1 at n+1.
  - Each cycle of HREADY=0 adds one cycle.
- Simultaneous events:
  - Owner drops its request while the other raises: handover occurs in the same evaluation.
  - Both drop: GNT_DEF.
- HMASTER never takes the value 3.

Test Plan:
- Reset then idle: after HRESETn rises with no requests and HREADY=1 for 5 cycles -> HGRANT_M1=HGRANT_M2=0, HMASTER=0, HMASTLOCK=0 throughout.
- Single request: HBUSREQ_M1=1 at cycle 0, HREADY=1 -> HGRANT_M1=1 at cycle 1, HMASTER=1 at cycle 2. M1 drops its request at cycle 5 -> grant state GNT_DEF at cycle 6, HMASTER=0 at cycle 7.
- Priority: both request at the same edge -> RR_MODE=0 grants M1. RR_MODE=1 grants M1 first; after M1 releases, M2 is granted; on the next tie M1 wins again.
- Beat cap: MAX_BEATS=4, M1 owns and issues NONSEQ + 3 SEQ with HREADY=1 while M2 requests -> grant moves to M2 on the edge after the 4th counted beat. Repeat with MAX_BEATS=0 -> M1 keeps the grant indefinitely.
- Lock: M1 owns with HLOCK_M1=1 and MAX_BEATS=2 while M2 requests for 10 beats -> HGRANT_M1 stays 1 and HMASTLOCK=1. Deassert HLOCK_M1 and HBUSREQ_M1 -> M2 granted on the next HREADY edge, HMASTLOCK=0.
- Wait states and async reset: HREADY=0 for 3 cycles during a handover -> HMASTER stays at its old value until the first HREADY=1 edge. Assert HRESETn=0 mid-burst -> all outputs become 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter: CPU (M1), DMA (M2), default master 0.
// Fixed or round-robin priority, locked transfers, burst fairness cap.
module ahb_arbiter #(
  parameter int RR_MODE   = 0,
  parameter int MAX_BEATS = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       HBUSREQ_M1,
  input  logic       HLOCK_M1,
  input  logic       HBUSREQ_M2,
  input  logic       HLOCK_M2,
  output logic       HGRANT_M1,
  output logic       HGRANT_M2,
  output logic [1:0] HMASTER,
  output logic       HMASTLOCK
);

  localparam logic [1:0] GNT_DEF = 2'd0;
  localparam logic [1:0] GNT_M1  = 2'd1;
  localparam logic [1:0] GNT_M2  = 2'd2;

  localparam logic [7:0] CAP = 8'(MAX_BEATS);

  logic [1:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] hmaster_q, hmaster_d;
  logic       hmastlock_q, hmastlock_d;

  logic       own_req, own_lock, oth_req;
  logic [1:0] oth, pick;
  logic       cap_ok, keep, beat;

  // Owner view, retention test and next grant state.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    oth      = GNT_DEF;
    if (state_q == GNT_M1) begin
      own_req  = HBUSREQ_M1;
      own_lock = HLOCK_M1;
      oth_req  = HBUSREQ_M2;
      oth      = GNT_M2;
    end else if (state_q == GNT_M2) begin
      own_req  = HBUSREQ_M2;
      own_lock = HLOCK_M2;
      oth_req  = HBUSREQ_M1;
      oth      = GNT_M1;
    end

    cap_ok = (MAX_BEATS == 0) || (cnt_q < CAP) || !oth_req;
    keep   = (state_q != GNT_DEF) &&
             (own_lock || hmastlock_q || (own_req && cap_ok));

    unique case ({HBUSREQ_M2, HBUSREQ_M1})
      2'b11: begin
        if (RR_MODE != 0 && last_q == GNT_M1) pick = GNT_M2;
        else pick = GNT_M1;
      end
      2'b01:   pick = GNT_M1;
      2'b10:   pick = GNT_M2;
      default: pick = GNT_DEF;
    endcase

    // A failed owner either released or hit the fairness cap
    // with the other master waiting: it never wins straight back.
    if (keep)                    state_d = state_q;
    else if (state_q == GNT_DEF) state_d = pick;
    else if (oth_req)            state_d = oth;
    else                         state_d = GNT_DEF;

    beat = (state_q != GNT_DEF) && (hmaster_q == state_q) &&
           ((HTRANS == 2'b10) || (HTRANS == 2'b11));

    if (state_d != state_q)             cnt_d = 8'd0;
    else if (beat && cnt_q != 8'hFF)    cnt_d = cnt_q + 8'd1;
    else                                cnt_d = cnt_q;

    if (state_d != state_q && state_d != GNT_DEF) last_d = state_d;
    else                                           last_d = last_q;

    hmaster_d   = state_q;
    hmastlock_d = own_lock;
  end

  // All arbitration state advances only at transfer boundaries.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= GNT_DEF;
      last_q      <= GNT_M2;
      cnt_q       <= 8'd0;
      hmaster_q   <= GNT_DEF;
      hmastlock_q <= 1'b0;
    end else if (HREADY) begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign HGRANT_M1 = (state_q == GNT_M1);
  assign HGRANT_M2 = (state_q == GNT_M2);
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: three configurations share one stimulus,
// each checked against a rule-level reference model.
module tb_ahb_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       HREADY;
  logic [1:0] HTRANS;
  logic       HBUSREQ_M1, HLOCK_M1, HBUSREQ_M2, HLOCK_M2;

  logic [2:0] g1, g2, ml;
  logic [1:0] hmv [3];

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.RR_MODE(0), .MAX_BEATS(4)) u_f (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
    .HBUSREQ_M1(HBUSREQ_M1), .HLOCK_M1(HLOCK_M1),
    .HBUSREQ_M2(HBUSREQ_M2), .HLOCK_M2(HLOCK_M2),
    .HGRANT_M1(g1[0]), .HGRANT_M2(g2[0]),
    .HMASTER(hmv[0]), .HMASTLOCK(ml[0]));

  ahb_arbiter #(.RR_MODE(1), .MAX_BEATS(2)) u_r (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
    .HBUSREQ_M1(HBUSREQ_M1), .HLOCK_M1(HLOCK_M1),
    .HBUSREQ_M2(HBUSREQ_M2), .HLOCK_M2(HLOCK_M2),
    .HGRANT_M1(g1[1]), .HGRANT_M2(g2[1]),
    .HMASTER(hmv[1]), .HMASTLOCK(ml[1]));

  ahb_arbiter #(.RR_MODE(0), .MAX_BEATS(0)) u_n (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
    .HBUSREQ_M1(HBUSREQ_M1), .HLOCK_M1(HLOCK_M1),
    .HBUSREQ_M2(HBUSREQ_M2), .HLOCK_M2(HLOCK_M2),
    .HGRANT_M1(g1[2]), .HGRANT_M2(g2[2]),
    .HMASTER(hmv[2]), .HMASTLOCK(ml[2]));

  typedef struct {
    int owner;
    int beats;
    int last;
    int hm;
    bit hl;
  } mdl_t;

  mdl_t m [3];

  function automatic int rr_of(int c);
    return (c == 1) ? 1 : 0;
  endfunction

  function automatic int mb_of(int c);
    return (c == 0) ? 4 : (c == 1) ? 2 : 0;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.owner = 0; r.beats = 0; r.last = 2; r.hm = 0; r.hl = 1'b0;
    return r;
  endfunction

  // Arbitration rules stated on master numbers 0/1/2.
  function automatic mdl_t mdl_next(mdl_t s, int rr, int mb);
    mdl_t n;
    bit req [3];
    bit lk [3];
    int o, oth, nxt;
    bit keep;
    n = s;
    if (!HREADY) return n;
    req[0] = 1'b0; req[1] = HBUSREQ_M1; req[2] = HBUSREQ_M2;
    lk[0]  = 1'b0; lk[1]  = HLOCK_M1;   lk[2]  = HLOCK_M2;
    o   = s.owner;
    oth = 3 - o;
    keep = 1'b0;
    if (o != 0)
      keep = lk[o] || s.hl ||
             (req[o] && (mb == 0 || s.beats < mb || !req[oth]));
    if (keep) nxt = o;
    else if (o != 0) nxt = req[oth] ? oth : 0;
    else if (req[1] && req[2]) nxt = (rr != 0 && s.last == 1) ? 2 : 1;
    else if (req[1]) nxt = 1;
    else if (req[2]) nxt = 2;
    else nxt = 0;
    if (nxt != o) n.beats = 0;
    else if (o != 0 && s.hm == o && HTRANS[1] && s.beats < 255)
      n.beats = s.beats + 1;
    if (nxt != o && nxt != 0) n.last = nxt;
    n.hm    = o;
    n.hl    = (o == 0) ? 1'b0 : lk[o];
    n.owner = nxt;
    return n;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int c = 0; c < 3; c++) m[c] <= mdl_reset();
    end else begin
      for (int c = 0; c < 3; c++) m[c] <= mdl_next(m[c], rr_of(c), mb_of(c));
    end
  end

  function automatic logic [4:0] expv(int c);
    return {m[c].owner == 1, m[c].owner == 2, 2'(m[c].hm), m[c].hl};
  endfunction

  function automatic logic [4:0] actv(int c);
    return {g1[c], g2[c], hmv[c], ml[c]};
  endfunction

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle_in();
    HREADY = 1'b1; HTRANS = 2'b00;
    HBUSREQ_M1 = 1'b0; HLOCK_M1 = 1'b0;
    HBUSREQ_M2 = 1'b0; HLOCK_M2 = 1'b0;
  endtask

  task automatic rst_pulse();
    idle_in();
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({g1, g2, ml, hmv[0], hmv[1], hmv[2]} !== 15'd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got %b want 0", i,
                 {g1, g2, ml, hmv[0], hmv[1], hmv[2]});
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL reset_mdl dut%0d got %b want %b", c, actv(c), expv(c));
        end
      end
    end
  endtask

  task automatic test_single();
    rst_pulse();
    HBUSREQ_M1 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) HBUSREQ_M1 = 1'b0;
      step();
      if (i == 1) begin
        checks++;
        if (g1[0] !== 1'b1 || hmv[0] !== 2'd0) begin
          errors++;
          $display("FAIL single_grant got g1=%b hm=%0d want 1/0", g1[0], hmv[0]);
        end
      end
      if (i == 2) begin
        checks++;
        if (hmv[0] !== 2'd1) begin
          errors++;
          $display("FAIL single_hmaster got %0d want 1", hmv[0]);
        end
      end
      if (i == 6) begin
        checks++;
        if (g1[0] !== 1'b0 || hmv[0] !== 2'd1) begin
          errors++;
          $display("FAIL single_release got g1=%b hm=%0d want 0/1", g1[0], hmv[0]);
        end
      end
      if (i == 7) begin
        checks++;
        if (hmv[0] !== 2'd0) begin
          errors++;
          $display("FAIL single_hm_def got %0d want 0", hmv[0]);
        end
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL single_mdl dut%0d got %b want %b", c, actv(c), expv(c));
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [1:0] reqs [6];
    logic [1:0] want_r [6];
    reqs   = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
    want_r = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      {HBUSREQ_M2, HBUSREQ_M1} = reqs[i];
      step();
      checks++;
      if ({g2[1], g1[1]} !== want_r[i]) begin
        errors++;
        $display("FAIL prio_rr step%0d got %b want %b", i, {g2[1], g1[1]}, want_r[i]);
      end
      if (i == 0) begin
        checks++;
        if (g1[0] !== 1'b1) begin
          errors++;
          $display("FAIL prio_fixed got %b want 1", g1[0]);
        end
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL prio_mdl dut%0d got %b want %b", c, actv(c), expv(c));
        end
      end
    end
  endtask

  task automatic test_beat_cap();
    rst_pulse();
    HBUSREQ_M1 = 1'b1;
    HBUSREQ_M2 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) HTRANS = 2'b10;
      if (i == 4) HTRANS = 2'b11;
      step();
      if (i == 6) begin
        checks++;
        if (g1[0] !== 1'b1) begin
          errors++;
          $display("FAIL cap_hold got %b want 1", g1[0]);
        end
      end
      if (i == 7) begin
        checks++;
        if (g2[0] !== 1'b1 || g1[0] !== 1'b0) begin
          errors++;
          $display("FAIL cap_move got g1=%b g2=%b want 0/1", g1[0], g2[0]);
        end
      end
      if (i == 12) begin
        checks++;
        if (g1[2] !== 1'b1) begin
          errors++;
          $display("FAIL nocap_keep got %b want 1", g1[2]);
        end
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL cap_mdl dut%0d got %b want %b", c, actv(c), expv(c));
        end
      end
    end
  endtask

  task automatic test_lock();
    rst_pulse();
    HBUSREQ_M1 = 1'b1;
    HLOCK_M1   = 1'b1;
    HBUSREQ_M2 = 1'b1;
    HTRANS     = 2'b11;
    for (int i = 1; i <= 14; i++) begin
      if (i == 13) begin
        HBUSREQ_M1 = 1'b0;
        HLOCK_M1   = 1'b0;
      end
      step();
      if (i >= 3 && i <= 12) begin
        checks++;
        if (g1[1] !== 1'b1 || ml[1] !== 1'b1) begin
          errors++;
          $display("FAIL lock_hold cyc%0d got g1=%b lk=%b want 1/1", i, g1[1], ml[1]);
        end
      end
      if (i == 13) begin
        checks++;
        if (ml[1] !== 1'b0) begin
          errors++;
          $display("FAIL lock_clear got %b want 0", ml[1]);
        end
      end
      if (i == 14) begin
        checks++;
        if (g2[1] !== 1'b1) begin
          errors++;
          $display("FAIL lock_handover got %b want 1", g2[1]);
        end
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL lock_mdl dut%0d got %b want %b", c, actv(c), expv(c));
        end
      end
    end
  endtask

  task automatic test_wait_reset();
    rst_pulse();
    HBUSREQ_M1 = 1'b1;
    step();
    step();
    HBUSREQ_M1 = 1'b0;
    HBUSREQ_M2 = 1'b1;
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (hmv[0] !== 2'd1 || g2[0] !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold cyc%0d got hm=%0d g2=%b want 1/1", i, hmv[0], g2[0]);
      end
    end
    HREADY = 1'b1;
    HTRANS = 2'b10;
    step();
    checks++;
    if (hmv[0] !== 2'd2) begin
      errors++;
      $display("FAIL wait_release got %0d want 2", hmv[0]);
    end
    step();
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({g1, g2, ml, hmv[0], hmv[1], hmv[2]} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got %b want 0", {g1, g2, ml, hmv[0], hmv[1], hmv[2]});
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (actv(c) !== expv(c)) begin
        errors++;
        $display("FAIL areset_mdl dut%0d got %b want %b", c, actv(c), expv(c));
      end
    end
    @(negedge HCLK);
    idle_in();
    HRESETn = 1'b1;
  endtask

  task automatic test_random();
    rst_pulse();
    for (int i = 0; i < 600; i++) begin
      HREADY     = ($urandom_range(0, 4) != 0);
      HTRANS     = 2'($urandom_range(0, 3));
      HBUSREQ_M1 = ($urandom_range(0, 2) != 0);
      HBUSREQ_M2 = ($urandom_range(0, 2) != 0);
      HLOCK_M1   = ($urandom_range(0, 9) == 0);
      HLOCK_M2   = ($urandom_range(0, 9) == 0);
      step();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (actv(c) !== expv(c)) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d got %b want %b", i, c, actv(c), expv(c));
        end
        checks++;
        if (hmv[c] === 2'd3 || (g1[c] & g2[c]) !== 1'b0) begin
          errors++;
          $display("FAIL onehot cyc%0d dut%0d got g=%b%b hm=%0d", i, c, g1[c], g2[c], hmv[c]);
        end
      end
    end
  endtask

  initial begin
    idle_in();
    HRESETn = 1'b0;
    @(negedge HCLK);
    test_reset();
    test_single();
    test_priority();
    test_beat_cap();
    test_lock();
    test_wait_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
